commit_trace_serializer: RTL and testbench
==========================================

// Module: commit_trace_serializer
// PURPOSE
//  Collects per-cycle retirement events (up to COMMITS instructions plus one trap) from the core
//  pipeline and buffers them in an in-order FIFO. Drains them one event per handshake to the
//  cosim checker, which issues one commit/judge/raise_trap DPI call per event.
//  Sits between the core's commit ports and the difftest checker in the testbench harness.
//  The core is never stalled. Overflow is detected, counted and flagged, never silently lost.
// PARAMETERS
//  COMMITS  2   retirement ports per cycle; slot 0 is oldest
//  DEPTH    16  FIFO entries; power of two, >= COMMITS+1
//  XLEN     64  pc/wdata/cause width
// PORTS
//  clock        in   1            rising-edge clock
//  reset        in   1            asynchronous, active-high; clears all state
//  in_valid     in   COMMITS      per-slot retirement valid
//  in_pc        in   COMMITS*XLEN slot i at [i*XLEN +: XLEN]
//  in_insn      in   COMMITS*32   raw instruction bits per slot
//  in_wen       in   COMMITS      slot writes a register
//  in_waddr     in   COMMITS*6    {fp,rd[4:0]} destination per slot
//  in_wdata     in   COMMITS*XLEN writeback data per slot
//  trap_valid   in   1            trap/interrupt taken this cycle
//  trap_cause   in   XLEN         mcause-format cause, valid with trap_valid
//  out_valid    out  1            head event available
//  out_ready    in   1            checker consumes head this cycle
//  out_kind     out  1            0 = commit, 1 = trap
//  out_pc       out  XLEN         commit pc (trap: 0)
//  out_insn     out  32           commit insn (trap: 0)
//  out_wen      out  1            commit wen (trap: 0)
//  out_waddr    out  6            commit waddr (trap: 0)
//  out_wdata    out  XLEN         commit wdata; trap: cause
//  out_seq      out  32           event sequence number, starts at 0
//  level        out  log2(DEPTH)+1  current occupancy
//  overflow     out  1            sticky: at least one batch was dropped
//  drop_count   out  16           dropped events, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (async, asserted): rd/wr pointers=0, level=0, seq counter=0, overflow=0, drop_count=0.
//    Consequently out_valid=0. Entry storage is not reset. An in-flight batch is lost without being counted.
//  - Batch per cycle: valid slots are packed in ascending slot order, then the trap entry if
//    trap_valid. Batch size N = popcount(in_valid)+trap_valid, range 0..COMMITS+1.
//  - Free space = DEPTH - level + (out_valid & out_ready). A same-cycle dequeue frees its slot for the batch.
//  - If N <= free: all N entries are written at wr_ptr..wr_ptr+N-1 (mod DEPTH). wr_ptr += N.
//    Each entry gets seq = seq_ctr+k (k=0..N-1). seq_ctr += N, wrapping at 2^32.
//  - If N > free: the whole batch is dropped and nothing is partially written. overflow<=1.
//    drop_count += N, saturating. seq_ctr += N anyway, so the checker sees a seq gap.
//  - Output is a fall-through from the head entry. out_valid = (level != 0).
//    Fields are combinational from entry[rd_ptr]. Handshake = out_valid & out_ready.
//    On a handshake, rd_ptr += 1 (mod DEPTH) at the next edge.
//  - out_* fields are held stable while out_valid=1 and out_ready=0.
//    out_ready while out_valid=0 is ignored.
//  - level_next = level + N_accepted - handshake. level never exceeds DEPTH.
//  - An event is never visible on out_* in the cycle it is written. Minimum latency is 1 cycle.
//  - Empty plus batch in the same cycle: there is no bypass. out_valid rises at the next edge.
//  - Full plus handshake plus a batch of N=1: accepted. Level stays at DEPTH.
//  - Pointers are log2(DEPTH) bits and wrap naturally. level disambiguates full/empty.
//  - Inputs with in_valid[i]=0 are don't-care, including X.
// TESTING
//  1 reset, slot0 pc=0x80000000 insn=0x00000013 -> next cycle out_valid=1, seq=0, kind=0. level 1->0 after ready.
//  2 both slots valid (0x80000004, 0x80000008) + trap cause=0x2 in one cycle, ready=1 ->
//    3 events in order 0x..04, 0x..08, trap(wdata=2), seq 0,1,2.
//  3 ready=0, fill with 8 two-slot batches (DEPTH=16) -> level=16. Next batch of 2 is dropped:
//    overflow=1, drop_count=2. The next accepted event has seq=18.
//  4 level=16, one-slot batch + handshake in the same cycle -> accepted, level stays 16, no drop.
//  5 head held with ready=0 for 5 cycles -> out_* stable. Wrap: push/pop 40 events -> seq 0..39 in order.
//  6 assert reset mid-drain with level=7 -> out_valid=0 immediately (async), level=0, overflow=0, seq restarts at 0.

Source files
------------

// File: rtl/commit_trace_serializer.sv
// Retirement-event serializer: packs per-cycle commits plus an optional trap into an
// in-order FIFO and drains one event per handshake towards the cosim checker.
module commit_trace_serializer #(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 16,
  parameter int XLEN    = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COMMITS-1:0]      in_valid,
  input  logic [COMMITS*XLEN-1:0] in_pc,
  input  logic [COMMITS*32-1:0]   in_insn,
  input  logic [COMMITS-1:0]      in_wen,
  input  logic [COMMITS*6-1:0]    in_waddr,
  input  logic [COMMITS*XLEN-1:0] in_wdata,
  input  logic                    trap_valid,
  input  logic [XLEN-1:0]         trap_cause,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_kind,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_insn,
  output logic                    out_wen,
  output logic [5:0]              out_waddr,
  output logic [XLEN-1:0]         out_wdata,
  output logic [31:0]             out_seq,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = LW + 1;
  localparam int BW = $clog2(COMMITS + 2);

  typedef struct packed {
    logic            kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            wen;
    logic [5:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [31:0]     seq;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          batch [COMMITS+1];
  entry_t          head;
  logic [BW-1:0]   pos;
  logic [BW-1:0]   n_cnt;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     seq_q, seq_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;

  logic            hs;
  logic [CW-1:0]   free_w;
  logic            accept;
  logic [16:0]     drop_sum;

  // Pack valid slots oldest-first, trap last; each entry takes the next sequence number.
  always_comb begin
    pos = '0;
    for (int k = 0; k <= COMMITS; k++) batch[k] = '0;
    for (int i = 0; i < COMMITS; i++) begin
      if (in_valid[i]) begin
        batch[pos].kind  = 1'b0;
        batch[pos].pc    = in_pc[i*XLEN +: XLEN];
        batch[pos].insn  = in_insn[i*32 +: 32];
        batch[pos].wen   = in_wen[i];
        batch[pos].waddr = in_waddr[i*6 +: 6];
        batch[pos].wdata = in_wdata[i*XLEN +: XLEN];
        batch[pos].seq   = seq_q + 32'(pos);
        pos = pos + 1'b1;
      end
    end
    if (trap_valid) begin
      batch[pos].kind  = 1'b1;
      batch[pos].wdata = trap_cause;
      batch[pos].seq   = seq_q + 32'(pos);
      pos = pos + 1'b1;
    end
    n_cnt = pos;
  end

  // A same-cycle dequeue frees its slot for the incoming batch.
  always_comb begin
    hs       = out_valid & out_ready;
    free_w   = CW'(DEPTH) - CW'(level_q) + CW'(hs);
    accept   = (CW'(n_cnt) <= free_w);
    drop_sum = 17'(drop_q) + 17'(n_cnt);

    wr_ptr_d = accept ? wr_ptr_q + PW'(n_cnt) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PW'(hs);
    level_d  = level_q + (accept ? LW'(n_cnt) : LW'(0)) - LW'(hs);
    seq_d    = seq_q + 32'(n_cnt);
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (!accept) begin
      ovf_d  = 1'b1;
      drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage carries no reset; level alone decides what is visible.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k <= COMMITS; k++) begin
        if (BW'(k) < n_cnt) mem_q[wr_ptr_q + PW'(k)] <= batch[k];
      end
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = (level_q != '0);
    out_kind   = head.kind;
    out_pc     = head.pc;
    out_insn   = head.insn;
    out_wen    = head.wen;
    out_waddr  = head.waddr;
    out_wdata  = head.wdata;
    out_seq    = head.seq;
    level      = level_q;
    overflow   = ovf_q;
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed bench for commit_trace_serializer: queue-based event model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_commit_trace_serializer;
  localparam int COMMITS = 2;
  localparam int DEPTH   = 16;
  localparam int XLEN    = 64;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [COMMITS-1:0]      in_valid;
  logic [COMMITS*XLEN-1:0] in_pc;
  logic [COMMITS*32-1:0]   in_insn;
  logic [COMMITS-1:0]      in_wen;
  logic [COMMITS*6-1:0]    in_waddr;
  logic [COMMITS*XLEN-1:0] in_wdata;
  logic                    trap_valid;
  logic [XLEN-1:0]         trap_cause;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_kind;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic [5:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic [31:0]             out_seq;
  logic [4:0]              level;
  logic                    overflow;
  logic [15:0]             drop_count;

  commit_trace_serializer #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_wen(in_wen),
    .in_waddr(in_waddr), .in_wdata(in_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_insn(out_insn), .out_wen(out_wen), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .out_seq(out_seq), .level(level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [5:0]  waddr;
    logic [63:0] wdata;
    logic [31:0] seq;
  } ev_t;

  ev_t         mq[$];
  ev_t         bq[$];
  ev_t         e;
  logic [31:0] m_seq;
  logic        m_ovf;
  int          m_drop;
  int          m_free;
  bit          m_hs;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ins(input logic [63:0] p);
    return {p[15:0], 16'h0013};
  endfunction

  // Model: FIFO of events; a batch is all-or-nothing against free space.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_seq  = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      bq.delete();
      for (int i = 0; i < COMMITS; i++) begin
        if (in_valid[i]) begin
          e.kind  = 1'b0;
          e.pc    = in_pc[i*XLEN +: XLEN];
          e.insn  = in_insn[i*32 +: 32];
          e.wen   = in_wen[i];
          e.waddr = in_waddr[i*6 +: 6];
          e.wdata = in_wdata[i*XLEN +: XLEN];
          e.seq   = '0;
          bq.push_back(e);
        end
      end
      if (trap_valid) begin
        e.kind = 1'b1; e.pc = '0; e.insn = '0; e.wen = 1'b0; e.waddr = '0;
        e.wdata = trap_cause; e.seq = '0;
        bq.push_back(e);
      end
      m_hs   = (mq.size() != 0) && out_ready;
      m_free = DEPTH - mq.size() + (m_hs ? 1 : 0);
      if (m_hs) void'(mq.pop_front());
      if (bq.size() <= m_free) begin
        for (int k = 0; k < bq.size(); k++) begin
          e = bq[k];
          e.seq = m_seq + k;
          mq.push_back(e);
        end
      end else begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + bq.size() > 65535) ? 65535 : m_drop + bq.size();
      end
      m_seq = m_seq + bq.size();
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("cyc_valid", out_valid, mq.size() != 0);
      chk("cyc_level", level, mq.size());
      chk("cyc_overflow", overflow, m_ovf);
      chk("cyc_drop", drop_count, m_drop);
      if (mq.size() != 0) begin
        chk("cyc_kind", out_kind, mq[0].kind);
        chk("cyc_pc", out_pc, mq[0].pc);
        chk("cyc_insn", out_insn, mq[0].insn);
        chk("cyc_wen", out_wen, mq[0].wen);
        chk("cyc_waddr", out_waddr, mq[0].waddr);
        chk("cyc_wdata", out_wdata, mq[0].wdata);
        chk("cyc_seq", out_seq, mq[0].seq);
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                      input logic tv, input logic [63:0] cause, input logic rdy);
    in_valid   = v;
    in_pc      = {p1, p0};
    in_insn    = {ins(p1), ins(p0)};
    in_wen     = {p1[2], p0[2]};
    in_waddr   = {p1[7:2], p0[7:2]};
    in_wdata   = {~p1, ~p0};
    trap_valid = tv;
    trap_cause = cause;
    out_ready  = rdy;
    @(negedge clock);
    in_valid   = '0;
    trap_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 64'h0, 64'h0, 1'b0, 64'h0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0; in_pc = '0; in_insn = '0; in_wen = '0; in_waddr = '0; in_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 0);
    reset = 1'b0;

    // Single commit, one-cycle latency, then drained.
    step(2'b01, 64'h80000000, 64'hDEADBEEF, 1'b0, 64'h0, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_seq", out_seq, 0);
    chk("t1_kind", out_kind, 1'b0);
    chk("t1_pc", out_pc, 64'h80000000);
    chk("t1_insn", out_insn, 32'h00000013);
    chk("t1_level", level, 1);
    idle(1'b1);
    chk("t1_level_after", level, 0);
    chk("t1_valid_after", out_valid, 1'b0);

    // Two commits plus trap in one cycle.
    do_reset();
    step(2'b11, 64'h80000004, 64'h80000008, 1'b1, 64'h2, 1'b1);
    chk("t2_pc0", out_pc, 64'h80000004);
    chk("t2_seq0", out_seq, 0);
    chk("t2_level", level, 3);
    idle(1'b1);
    chk("t2_pc1", out_pc, 64'h80000008);
    chk("t2_seq1", out_seq, 1);
    idle(1'b1);
    chk("t2_kind_trap", out_kind, 1'b1);
    chk("t2_trap_wdata", out_wdata, 64'h2);
    chk("t2_trap_pc", out_pc, 64'h0);
    chk("t2_seq2", out_seq, 2);
    idle(1'b1);
    chk("t2_level_end", level, 0);

    // Fill to DEPTH, then a dropped batch.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(2'b11, 64'h1000 + 16*i, 64'h1008 + 16*i, 1'b0, 64'h0, 1'b0);
    chk("t3_full_level", level, 16);
    chk("t3_no_ovf", overflow, 1'b0);
    step(2'b11, 64'h2000, 64'h2008, 1'b0, 64'h0, 1'b0);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_drop", drop_count, 2);
    chk("t3_level", level, 16);

    // Full + handshake + single-slot batch is accepted.
    step(2'b01, 64'h3000, 64'h0, 1'b0, 64'h0, 1'b1);
    chk("t4_level", level, 16);
    chk("t4_drop", drop_count, 2);
    chk("t4_head_seq", out_seq, 1);
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("t3_gap_seq", out_seq, 18);
    chk("t3_gap_pc", out_pc, 64'h3000);
    chk("t3_gap_level", level, 1);
    idle(1'b1);

    // Head held stable under back-pressure.
    do_reset();
    step(2'b01, 64'h4000, 64'h0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    chk("t5_hold_pc", out_pc, 64'h4000);
    chk("t5_hold_insn", out_insn, 32'h40000013);
    chk("t5_hold_seq", out_seq, 0);
    chk("t5_hold_level", level, 1);
    idle(1'b1);

    // 40 events through the wrapping pointers.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 64'h5000 + 16*i, 64'h5008 + 16*i, 1'b0, 64'h0, 1'b1);
      if (i == 0) chk("t5_wrap_first", out_seq, 0);
      idle(1'b1);
    end
    chk("t5_wrap_last_seq", out_seq, 39);
    idle(1'b1);
    chk("t5_wrap_level", level, 0);
    chk("t5_wrap_ovf", overflow, 1'b0);

    // Asynchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < 9; i++)
      step(2'b11, 64'h6000 + 16*i, 64'h6008 + 16*i, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);
    chk("t6_level7", level, 7);
    chk("t6_ovf_pre", overflow, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_level", level, 0);
    chk("t6_async_ovf", overflow, 1'b0);
    chk("t6_async_drop", drop_count, 0);
    @(negedge clock);
    reset = 1'b0;
    step(2'b01, 64'h7000, 64'h0, 1'b0, 64'h0, 1'b0);
    chk("t6_seq_restart", out_seq, 0);
    chk("t6_valid", out_valid, 1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
